// File: rtl/ro_puf_pkg.sv
// Shared types and constants for the RO-PUF window counter.
//   state_t : measurement FSM states
//   DEF_*   : default widths and channel count
//   ch_off  : bit offset of channel ch inside a flattened count bus
package ro_puf_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    COUNT,
    DONE
  } state_t;

  localparam int DEF_NUM_CH      = 2;
  localparam int DEF_CNT_W       = 32;
  localparam int DEF_WIN_W       = 16;
  localparam int DEF_SYNC_STAGES = 2;

  function automatic int ch_off(input int ch, input int cnt_w);
    return ch * cnt_w;
  endfunction

endpackage

// File: rtl/ro_edge_sync.sv
// Synchroniser plus rising-edge detector for one RO channel.
//   clk   : reference clock
//   reset : synchronous active-high reset
//   ro    : raw ring-oscillator output, asynchronous to clk
//   rise  : one-cycle pulse when the synchronised RO goes 0 -> 1
module ro_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic ro,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sff;
  logic                   dly;

  always_ff @(posedge clk) begin
    if (reset) begin
      sff <= '0;
      dly <= 1'b0;
    end else begin
      sff <= {sff[SYNC_STAGES-2:0], ro};
      dly <= sff[SYNC_STAGES-1];
    end
  end

  assign rise = sff[SYNC_STAGES-1] & ~dly;

endmodule

// File: rtl/ro_window_counter.sv
// Counts rising edges of NUM_CH ring oscillators over a window of win_len
// reference clocks, latches the counts with saturation flags and produces
// a PUF response bit (count[1] > count[0]).
//   clk, reset : reference clock, synchronous active-high reset
//   start      : measurement request, honoured only when idle
//   win_len    : window length in clk cycles, sampled with start (0 ignored)
//   ro_in      : raw RO outputs
//   busy       : measurement in progress
//   done       : one-cycle strobe when results update
//   count_flat : latched counts, channel i at [i*CNT_W +: CNT_W]
//   sat        : latched per-channel saturation flags
//   resp       : latched response bit
module ro_window_counter
  import ro_puf_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int WIN_W       = DEF_WIN_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [WIN_W-1:0]        win_len,
  input  logic [NUM_CH-1:0]       ro_in,
  output logic                    busy,
  output logic                    done,
  output logic [NUM_CH*CNT_W-1:0] count_flat,
  output logic [NUM_CH-1:0]       sat,
  output logic                    resp
);

  state_t                         state;
  logic [WIN_W-1:0]               wcnt;
  logic [NUM_CH-1:0]              rise;
  logic [NUM_CH-1:0][CNT_W-1:0]   cnt, cnt_nxt, res;
  logic [NUM_CH-1:0]              wsat, wsat_nxt;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ro_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .reset (reset),
      .ro    (ro_in[g]),
      .rise  (rise[g])
    );
    assign count_flat[ch_off(g, CNT_W) +: CNT_W] = res[g];
  end

  // Working counters advance only in COUNT; an all-ones counter holds and
  // marks the channel saturated instead of wrapping.
  always_comb begin
    cnt_nxt  = cnt;
    wsat_nxt = wsat;
    if (state == COUNT) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (rise[c]) begin
          if (&cnt[c]) wsat_nxt[c] = 1'b1;
          else         cnt_nxt[c]  = cnt[c] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      wcnt  <= '0;
      cnt   <= '0;
      wsat  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      res   <= '0;
      sat   <= '0;
      resp  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && (win_len != '0)) begin
            state <= ARM;
            wcnt  <= win_len;
            cnt   <= '0;
            wsat  <= '0;
            busy  <= 1'b1;
          end
        end
        ARM: begin
          state <= COUNT;
          cnt   <= '0;
          wsat  <= '0;
        end
        COUNT: begin
          cnt  <= cnt_nxt;
          wsat <= wsat_nxt;
          wcnt <= wcnt - WIN_W'(1);
          // Last window cycle: latch using this cycle's increments too.
          if (wcnt == WIN_W'(1)) begin
            state <= DONE;
            done  <= 1'b1;
            res   <= cnt_nxt;
            sat   <= wsat_nxt;
            resp  <= (cnt_nxt[1] > cnt_nxt[0]);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
